md5_job_arbiter: RTL and testbench
==================================

Name: md5_job_arbiter

Overview:
- Shares one MD5 single-block hash core between NUM_REQ requesters.
- Grants requesters round-robin and buffers the granted requester's 16-word message block.
- Sequences the core's start / memory-read / result phases, then returns the 128-bit digest tagged with the requester id.
- Sits between the requester fabric and the core. The core's 4-bit word address reads this block's buffer directly.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of the requester id (clog2(NUM_REQ), minimum 1).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_REQ  per-requester word valid.
- in_ready  output  NUM_REQ  per-requester word ready.
- in_data  input  NUM_REQ*32  per-requester message word; requester k uses bits [32k+31:32k].
- core_start  output  1  start pulse to the core.
- core_addr  input  4  word address requested by the core.
- core_mem_read  input  1  core read strobe.
- core_chunk  output  32  buffer word at core_addr (combinational).
- core_hash  input  32  core result word.
- core_valid  input  1  core result-word strobe.
- out_valid  output  1  digest valid.
- out_ready  input  1  digest accepted.
- out_data  output  128  digest; first captured word in [127:96], last in [31:0].
- out_id  output  ID_W  requester that owns out_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=NUM_REQ-1, word_cnt=0, out_valid=0, core_start=0, in_ready=0, out_id=0, out_data=0.
  - Buffer contents are undefined after reset and are not cleared.
- States: IDLE -> LOAD -> START -> RUN -> CAPTURE -> DELIVER -> IDLE.
- IDLE:
  - Search in_valid starting at rr_ptr+1, wrapping at NUM_REQ; the first asserted requester wins.
  - On a win, latch grant id and set rr_ptr=id; next state LOAD the following cycle.
  - No winner: stay in IDLE.
- LOAD:
  - in_ready[grant]=1; all other in_ready bits are 0.
  - Each cycle with in_valid[grant]&in_ready[grant] writes buf[word_cnt] and increments word_cnt.
  - The 16th word (word_cnt==15 accepted) goes to START with word_cnt=0.
  - Bubbles (in_valid low) stall without timeout.
- START:
  - core_start=1 for exactly one cycle, then RUN.
  - A core_start pulse is never issued outside START.
- RUN:
  - core_chunk=buf[core_addr] combinationally, independent of core_mem_read.
  - Wait for core_valid.
- CAPTURE:
  - Entered on the first cycle core_valid is high; that cycle's core_hash is captured as word 0.
  - Words 1..3 are captured on the next three core_valid cycles; word 0 is placed in out_data[127:96].
  - After the 4th word: DELIVER with out_valid=1 and out_id=grant.
  - core_valid dropping mid-capture pauses the capture; the word count is kept.
- DELIVER:
  - out_valid and out_data are held stable until out_valid&out_ready.
  - After the handshake: out_valid=0, state IDLE.
  - Arbitration resumes in the cycle after the handshake; no requester is granted in the handshake cycle itself.
- Spurious core_valid in IDLE, LOAD, or START is ignored.
- Round-robin rules:
  - Grant order with all requesters valid: 0,1,...,NUM_REQ-1,0.
  - A single persistent requester is granted back-to-back.
- Throughput: one job in flight. Minimum cycles from grant to out_valid = 16 (LOAD) + 1 (START) + core latency + 4.
- Reset mid-job:
  - Returns to IDLE immediately and drops the partial block and digest.
  - out_valid deasserts asynchronously.
  - The core must be reset by the same reset.
- Ungranted requesters see in_ready=0 and must hold their data.

Test Plan:
- Single job:
  - Requester 0 streams words 0x00000080 followed by 15 zeros; a behavioural core returns 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Expect exactly one core_start pulse and core_chunk at address 0 = 0x00000080.
  - Expect out_data=0x11111111_22222222_33333333_44444444 and out_id=0.
- Contention: requesters 0 and 1 both valid continuously for 4 jobs -> out_id sequence 0,1,0,1, with no word interleaving in the buffer.
- Bubbles and backpressure:
  - Requester 1 deasserts in_valid every other cycle -> 16 words are captured in order with the correct core_chunk at every core_addr.
  - out_ready is held low 10 cycles -> out_data and out_id are stable and no new grant is made.
- Result gap: core_valid pattern 1,1,0,0,1,1 -> 4 words are captured in order and out_valid asserts only after the 4th.
- Reset during LOAD after 7 words, then a fresh 16-word job from requester 1 -> busy=0 right after reset, the new job completes normally, and no stale digest is produced.
- End-to-end with the real MD5 core on the padded block for "abc":
  - Build the padded block from "abc".
  - Compute the reference MD5 digest of "abc" in the bench.
  - Expect out_data to equal that digest, with its four 32-bit words in the order the core emits them.

Source files
------------

// File: rtl/md5_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : md5_job_arbiter
// Purpose : Round-robin front end that shares one MD5 block core between
//           NUM_REQ requesters, buffering one 16-word block per job.
// Revision: 1.0
// ============================================================================
module md5_job_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    in_valid,
    output logic [NUM_REQ-1:0]    in_ready,
    input  logic [NUM_REQ*32-1:0] in_data,
    output logic                  core_start,
    input  logic [3:0]            core_addr,
    input  logic                  core_mem_read,
    output logic [31:0]           core_chunk,
    input  logic [31:0]           core_hash,
    input  logic                  core_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_CAPTURE = 3'd4,
        S_DELIVER = 3'd5
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_q;
    logic [3:0]         word_cnt_q;
    logic [1:0]         cap_cnt_q;
    logic [NUM_REQ-1:0] in_ready_q;
    logic               core_start_q;
    logic               out_valid_q;
    logic [ID_W-1:0]    out_id_q;
    logic [127:0]       digest_q;
    logic [31:0]        msg_q [16];

    logic               grant_vld_d;
    logic [ID_W-1:0]    grant_d;
    int                 idx;
    logic               load_hs;
    logic [31:0]        load_word;
    logic               unused_mem_read;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_d     = '0;
        idx         = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_vld_d && in_valid[idx[ID_W-1:0]]) begin
                grant_vld_d = 1'b1;
                grant_d     = idx[ID_W-1:0];
            end
        end
    end

    assign load_hs   = (state_q == S_LOAD) && in_valid[grant_q] && in_ready_q[grant_q];
    assign load_word = in_data[{grant_q, 5'b00000} +: 32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= ID_W'(NUM_REQ - 1);
            grant_q      <= '0;
            word_cnt_q   <= 4'd0;
            cap_cnt_q    <= 2'd0;
            in_ready_q   <= '0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            digest_q     <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld_d) begin
                        grant_q    <= grant_d;
                        rr_ptr_q   <= grant_d;
                        in_ready_q <= NUM_REQ'(1) << grant_d;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_hs) begin
                        word_cnt_q <= word_cnt_q + 4'd1;
                        if (word_cnt_q == 4'd15) begin
                            in_ready_q   <= '0;
                            core_start_q <= 1'b1;
                            state_q      <= S_START;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (core_valid) begin
                        digest_q  <= {digest_q[95:0], core_hash};
                        cap_cnt_q <= 2'd1;
                        state_q   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (core_valid) begin
                        digest_q  <= {digest_q[95:0], core_hash};
                        cap_cnt_q <= cap_cnt_q + 2'd1;
                        if (cap_cnt_q == 2'd3) begin
                            out_valid_q <= 1'b1;
                            out_id_q    <= grant_q;
                            state_q     <= S_DELIVER;
                        end
                    end
                end
                S_DELIVER: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Message buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_hs) begin
            msg_q[word_cnt_q] <= load_word;
        end
    end

    // The core may sample its word on any cycle, so the strobe is not needed.
    assign unused_mem_read = core_mem_read;

    assign core_chunk = msg_q[core_addr];
    assign in_ready   = in_ready_q;
    assign core_start = core_start_q;
    assign out_valid  = out_valid_q;
    assign out_data   = digest_q;
    assign out_id     = out_id_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_md5_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_md5_job_arbiter
// Purpose : Scoreboard bench with a behavioural MD5 core for md5_job_arbiter.
// Revision: 1.0
// ============================================================================
module tb_md5_job_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    in_valid;
    logic [NUM_REQ-1:0]    in_ready;
    logic [NUM_REQ*32-1:0] in_data;
    logic                  core_start;
    logic [3:0]            core_addr;
    logic                  core_mem_read;
    logic [31:0]           core_chunk;
    logic [31:0]           core_hash;
    logic                  core_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic [127:0]          out_data;
    logic [ID_W-1:0]       out_id;
    logic                  busy;

    md5_job_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .core_start(core_start), .core_addr(core_addr),
        .core_mem_read(core_mem_read), .core_chunk(core_chunk),
        .core_hash(core_hash), .core_valid(core_valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [511:0]    blk;
        logic [127:0]    dig;
    } job_t;

    job_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          n_starts = 0;
    int          n_done   = 0;
    logic        tb_valid [NUM_REQ];
    logic [31:0] tb_data  [NUM_REQ];
    bit          core_fixed;
    logic [127:0] fixed_dig;
    logic [7:0]  gap_pat;
    int          gap_len;

    always_comb begin
        in_valid = '0;
        in_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            in_valid[k]         = tb_valid[k];
            in_data[32*k +: 32] = tb_data[k];
        end
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // Reference MD5 compression of one block from the standard initial state.
    function automatic logic [127:0] md5_blk(input logic [511:0] m);
        int          sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        logic [31:0] a, b, c, d, f, k;
        int          g;
        real         sv;
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                f = (b & c) | (~b & d); g = i;
            end else if (i < 32) begin
                f = (d & b) | (~d & c); g = (5 * i + 1) % 16;
            end else if (i < 48) begin
                f = b ^ c ^ d; g = (3 * i + 5) % 16;
            end else begin
                f = c ^ (b | ~d); g = (7 * i) % 16;
            end
            sv = $sin(real'(i + 1));
            if (sv < 0.0) sv = -sv;
            k = 32'(longint'($floor(sv * 4294967296.0)));
            f = f + a + k + m[32*g +: 32];
            a = d; d = c; c = b;
            b = b + rotl(f, sh[(i / 16) * 4 + (i % 4)]);
        end
        return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    task automatic push_job(input int id, input logic [511:0] b, input logic [127:0] d);
        job_t e;
        e.id  = ID_W'(id);
        e.blk = b;
        e.dig = d;
        sb.push_back(e);
    endtask

    task automatic send_words(input int id, input logic [511:0] b, input int nw, input bit bubbles);
        int n   = 0;
        int cyc = 0;
        bit hs;
        while (n < nw && cyc < 3000) begin
            tb_valid[id] = !(bubbles && cyc[0]);
            tb_data[id]  = b[32*n +: 32];
            @(negedge clk);
            hs = tb_valid[id] && in_ready[id];
            @(posedge clk); #1;
            if (hs) n++;
            cyc++;
        end
        tb_valid[id] = 1'b0;
        if (n < nw) check("send_timeout", 128'(n), 128'(nw));
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain", 128'(sb.size()), 128'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) if (core_start === 1'b1) n_starts++;

    // Output monitor: each accepted digest must match the oldest pending job.
    always @(negedge clk) begin
        job_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("pending_jobs", 128'(sb.size()), 128'd1);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.dig);
                check("out_id", 128'(out_id), 128'(e.id));
                n_done++;
            end
        end
    end

    // Behavioural core: reads the block through core_addr, then returns 4 words.
    initial begin
        logic [511:0] rd;
        logic [511:0] exp_blk;
        logic [127:0] dig;
        int           w;
        int           s;
        bit           v;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1 && !reset) begin
                exp_blk = (sb.size() != 0) ? sb[0].blk : '0;
                for (int a = 0; a < 16; a++) begin
                    @(posedge clk); #1;
                    core_addr     = 4'(a);
                    core_mem_read = 1'b1;
                    @(negedge clk);
                    check("core_chunk", 128'(core_chunk), 128'(exp_blk[32*a +: 32]));
                    rd[32*a +: 32] = core_chunk;
                end
                @(posedge clk); #1;
                core_mem_read = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                dig = core_fixed ? fixed_dig : md5_blk(rd);
                w = 0;
                s = 0;
                while (w < 4) begin
                    v          = (s < gap_len) ? gap_pat[s] : 1'b1;
                    core_valid = v;
                    core_hash  = v ? dig[127 - 32*w -: 32] : 32'hdeadbeef;
                    @(posedge clk); #1;
                    if (v) w++;
                    if (w < 4) check("early_valid", 128'(out_valid), 128'd0);
                    s++;
                end
                core_valid = 1'b0;
                core_hash  = 32'h0;
                check("valid_after_4th", 128'(out_valid), 128'd1);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] b0, b1, b2, b3;
        int           cyc;
        for (int k = 0; k < NUM_REQ; k++) begin
            tb_valid[k] = 1'b0;
            tb_data[k]  = 32'h0;
        end
        reset = 1'b1; out_ready = 1'b1; core_valid = 1'b0; core_hash = 32'h0;
        core_addr = 4'h0; core_mem_read = 1'b0;
        core_fixed = 1'b0; fixed_dig = '0; gap_pat = 8'h00; gap_len = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_core_start", 128'(core_start), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_id", 128'(out_id), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        reset = 1'b0;

        // Single job with fixed core result.
        core_fixed = 1'b1;
        fixed_dig  = 128'h11111111_22222222_33333333_44444444;
        b0 = '0;
        b0[31:0] = 32'h00000080;
        push_job(0, b0, fixed_dig);
        send_words(0, b0, 16, 1'b0);
        wait_drain();
        check("single_start_pulses", 128'(n_starts), 128'd1);

        // Contention: grant order 0,1,0,1 after a fresh reset.
        pulse_reset();
        core_fixed = 1'b0;
        b0 = rand_blk(); b1 = rand_blk(); b2 = rand_blk(); b3 = rand_blk();
        push_job(0, b0, md5_blk(b0));
        push_job(1, b1, md5_blk(b1));
        push_job(0, b2, md5_blk(b2));
        push_job(1, b3, md5_blk(b3));
        fork
            begin send_words(0, b0, 16, 1'b0); send_words(0, b2, 16, 1'b0); end
            begin send_words(1, b1, 16, 1'b0); send_words(1, b3, 16, 1'b0); end
        join
        wait_drain();

        // Bubbles on requester 1.
        b0 = rand_blk();
        push_job(1, b0, md5_blk(b0));
        send_words(1, b0, 16, 1'b1);
        wait_drain();

        // Output backpressure with a competing requester waiting.
        out_ready = 1'b0;
        b0 = rand_blk(); b1 = rand_blk();
        push_job(1, b0, md5_blk(b0));
        push_job(0, b1, md5_blk(b1));
        fork
            send_words(1, b0, 16, 1'b0);
            begin
                cyc = 0;
                while (in_ready[1] !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
                send_words(0, b1, 16, 1'b0);
            end
            begin
                int c2 = 0;
                while (out_valid !== 1'b1 && c2 < 500) begin @(negedge clk); c2++; end
                check("bp_out_valid", 128'(out_valid), 128'd1);
                repeat (10) begin
                    @(negedge clk);
                    check("bp_hold_data", out_data, sb[0].dig);
                    check("bp_hold_id", 128'(out_id), 128'(sb[0].id));
                    check("bp_no_grant", 128'(in_ready), 128'd0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Result gap: core_valid pattern 1,1,0,0,1,1.
        core_fixed = 1'b1;
        fixed_dig  = 128'hcafef00d_0badc0de_12345678_9abcdef0;
        gap_pat    = 8'b0011_0011;
        gap_len    = 6;
        b0 = rand_blk();
        push_job(0, b0, fixed_dig);
        send_words(0, b0, 16, 1'b0);
        wait_drain();
        gap_len = 0;
        core_fixed = 1'b0;

        // Reset during LOAD after 7 words, then a fresh job from requester 1.
        b0 = rand_blk();
        send_words(0, b0, 7, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 128'(busy), 128'd0);
        check("rst_mid_in_ready", 128'(in_ready), 128'd0);
        check("rst_mid_out_valid", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        b1 = rand_blk();
        push_job(1, b1, md5_blk(b1));
        send_words(1, b1, 16, 1'b0);
        wait_drain();
        repeat (30) @(posedge clk);
        #1;
        check("no_stale_digest", 128'(out_valid), 128'd0);

        // End-to-end MD5 of "abc".
        b0 = '0;
        b0[31:0]        = 32'h80636261;
        b0[14*32 +: 32] = 32'd24;
        push_job(0, b0, md5_blk(b0));
        send_words(0, b0, 16, 1'b0);
        wait_drain();

        check("start_per_job", 128'(n_starts), 128'(n_done));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
